traffic_junction_ctrl: RTL



---
 rtl/traffic_junction_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/traffic_junction_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_junction_ctrl
// Description : Two-way junction signal controller with all-red clearance,
//               pedestrian green truncation, night flashing mode and a
//               two-digit 7-segment countdown display.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_junction_ctrl #(
    parameter int TICK_CYCLES   = 10000000,
    parameter int GREEN_TIME    = 15,
    parameter int YELLOW_TIME   = 3,
    parameter int ALL_RED_TIME  = 1,
    parameter int PED_GREEN_MAX = 5,
    localparam int CNT_W = $clog2(((GREEN_TIME > YELLOW_TIME)
                               ? ((GREEN_TIME > ALL_RED_TIME) ? GREEN_TIME : ALL_RED_TIME)
                               : ((YELLOW_TIME > ALL_RED_TIME) ? YELLOW_TIME : ALL_RED_TIME)) + 1)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             ped_req,
    input  logic             night_mode,
    output logic             ns_red,
    output logic             ns_yellow,
    output logic             ns_green,
    output logic             ew_red,
    output logic             ew_yellow,
    output logic             ew_green,
    output logic             ped_pend,
    output logic [CNT_W-1:0] cnt_out,
    output logic [6:0]       tens_digit_led,
    output logic [6:0]       unit_digit_led
);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    localparam int c_presc_w = $clog2(TICK_CYCLES);

    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_CYCLES - 1);
    localparam logic [c_presc_w-1:0] c_presc_one  = c_presc_w'(1);
    localparam logic [CNT_W-1:0]     c_green      = CNT_W'(GREEN_TIME);
    localparam logic [CNT_W-1:0]     c_yellow     = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0]     c_all_red    = CNT_W'(ALL_RED_TIME);
    localparam logic [CNT_W-1:0]     c_ped        = CNT_W'(PED_GREEN_MAX);
    localparam logic [CNT_W-1:0]     c_one        = CNT_W'(1);
    localparam logic [6:0]           c_rst_tens   = (GREEN_TIME < 10) ? 7'b0000000
                                                    : seg7(4'(GREEN_TIME / 10));
    localparam logic [6:0]           c_rst_unit   = seg7(4'(GREEN_TIME % 10));

    localparam logic [2:0] c_st_ns_green  = 3'd0;
    localparam logic [2:0] c_st_ns_yellow = 3'd1;
    localparam logic [2:0] c_st_red_a     = 3'd2;
    localparam logic [2:0] c_st_ew_green  = 3'd3;
    localparam logic [2:0] c_st_ew_yellow = 3'd4;
    localparam logic [2:0] c_st_red_b     = 3'd5;
    localparam logic [2:0] c_st_night     = 3'd6;

    logic [2:0]           r_state;
    logic [c_presc_w-1:0] r_presc;
    logic                 r_blink;

    logic [2:0]           w_state_nxt;
    logic [c_presc_w-1:0] w_presc_nxt;
    logic                 w_blink_nxt;
    logic                 w_pend_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_tick;
    logic                 w_pend_eff;
    logic                 w_is_green;
    logic [5:0]           w_lamps_nxt;
    logic [7:0]           w_cnt8;
    logic [6:0]           w_tens_nxt;
    logic [6:0]           w_unit_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_blink_nxt = r_blink;
        w_cnt_nxt   = cnt_out;
        w_pend_eff  = ped_pend | ped_req;
        w_pend_nxt  = w_pend_eff;
        w_tick      = 1'b0;
        w_is_green  = (r_state == c_st_ns_green) || (r_state == c_st_ew_green);

        if (en) begin
            w_tick      = (r_presc == c_presc_last);
            w_presc_nxt = w_tick ? '0 : r_presc + c_presc_one;

            // A pending request in green consumes this cycle, including any tick.
            if (w_is_green && w_pend_eff) begin
                if (cnt_out > c_ped) begin
                    w_cnt_nxt = c_ped;
                end
                w_pend_nxt = 1'b0;
            end else if (r_state == c_st_night) begin
                if (w_tick) begin
                    if (night_mode) begin
                        w_blink_nxt = ~r_blink;
                    end else begin
                        w_state_nxt = c_st_red_b;
                        w_cnt_nxt   = c_all_red;
                        w_blink_nxt = 1'b0;
                    end
                end
            end else if (w_tick) begin
                if (cnt_out > c_one) begin
                    w_cnt_nxt = cnt_out - c_one;
                end else begin
                    // Green always runs out through yellow before night can start.
                    case (r_state)
                        c_st_ns_green:  w_state_nxt = c_st_ns_yellow;
                        c_st_ns_yellow: w_state_nxt = night_mode ? c_st_night : c_st_red_a;
                        c_st_red_a:     w_state_nxt = night_mode ? c_st_night : c_st_ew_green;
                        c_st_ew_green:  w_state_nxt = c_st_ew_yellow;
                        c_st_ew_yellow: w_state_nxt = night_mode ? c_st_night : c_st_red_b;
                        default:        w_state_nxt = night_mode ? c_st_night : c_st_ns_green;
                    endcase

                    case (w_state_nxt)
                        c_st_ns_green, c_st_ew_green:   w_cnt_nxt = c_green;
                        c_st_ns_yellow, c_st_ew_yellow: w_cnt_nxt = c_yellow;
                        c_st_night: begin
                            w_cnt_nxt   = '0;
                            w_blink_nxt = 1'b1;
                        end
                        default:                        w_cnt_nxt = c_all_red;
                    endcase

                    if ((w_state_nxt == c_st_ns_green || w_state_nxt == c_st_ew_green)
                        && w_pend_eff) begin
                        w_cnt_nxt  = c_ped;
                        w_pend_nxt = 1'b0;
                    end
                end
            end
        end
    end

    // Lamp order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
    always_comb begin
        w_lamps_nxt = 6'b100100;
        case (w_state_nxt)
            c_st_ns_green:  w_lamps_nxt = 6'b001100;
            c_st_ns_yellow: w_lamps_nxt = 6'b010100;
            c_st_ew_green:  w_lamps_nxt = 6'b100001;
            c_st_ew_yellow: w_lamps_nxt = 6'b100010;
            c_st_night:     w_lamps_nxt = {1'b0, w_blink_nxt, 2'b00, w_blink_nxt, 1'b0};
            default:        w_lamps_nxt = 6'b100100;
        endcase
    end

    always_comb begin
        w_cnt8     = 8'(w_cnt_nxt);
        w_tens_nxt = 7'b0000000;
        w_unit_nxt = 7'b0000000;
        if (w_state_nxt != c_st_night) begin
            w_unit_nxt = seg7(4'(w_cnt8 % 8'd10));
            if (w_cnt8 >= 8'd10) begin
                w_tens_nxt = seg7(4'(w_cnt8 / 8'd10));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state        <= c_st_ns_green;
            r_presc        <= '0;
            r_blink        <= 1'b0;
            ped_pend       <= 1'b0;
            cnt_out        <= c_green;
            {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} <= 6'b001100;
            tens_digit_led <= c_rst_tens;
            unit_digit_led <= c_rst_unit;
        end else begin
            r_state        <= w_state_nxt;
            r_presc        <= w_presc_nxt;
            r_blink        <= w_blink_nxt;
            ped_pend       <= w_pend_nxt;
            cnt_out        <= w_cnt_nxt;
            {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} <= w_lamps_nxt;
            tens_digit_led <= w_tens_nxt;
            unit_digit_led <= w_unit_nxt;
        end
    end

endmodule
`default_nettype wire
